microwave_controller: RTL and testbench
=======================================

Name: microwave_controller

Overview:
- Sequencing FSM for the MM:SS countdown timer chain in the microwave design.
- Keypad digits are shifted into the timer through load pulses.
- Cook, pause and cancel are controlled by start/stop/door inputs.
- The block generates the one-per-second timer enable and drives the magnetron. It also drives the end-of-cook beep and clears the timer.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per one-second timer decrement; must be ≥2.
- BEEP_CYCLES, 100_000_000: clk cycles beep stays high in DONE; must be ≥1.
- MAX_DIGITS, 4: maximum keypad digits accepted per entry.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- key_valid  in  1  one-cycle strobe, keypad digit present.
- key_digit  in  4  BCD digit 0-9; values >9 are ignored, with no load issued.
- start  in  1  start/resume request, level-sampled.
- stop  in  1  pause/cancel request, level-sampled.
- door_open  in  1  door interlock; 1 = open.
- timer_finished  in  1  timer reached 00:00.
- timer_load  out  1  one-cycle pulse shifting timer_in into the timer chain.
- timer_in  out  4  digit presented with timer_load.
- timer_enabled  out  1  one-cycle decrement pulse to the timer.
- timer_clear  out  1  one-cycle synchronous clear to the timer.
- magnetron_on  out  1  high only in COOK.
- beep  out  1  high in DONE until timeout or acknowledge.
- state  out  3  IDLE=0, ENTRY=1, COOK=2, PAUSED=3, DONE=4.

Behaviour:
- Reset: all outputs registered.
  - state=IDLE; timer_load, timer_in, timer_enabled, timer_clear, magnetron_on and beep all 0.
  - digit_cnt=0; tick_cnt=0.
  - rst overrides every other input in the same cycle.
- Per-cycle input priority: stop > door_open > start > key_valid.
- IDLE:
  - Valid key: timer_load=1 and timer_in=key_digit on the next cycle; digit_cnt=1; go to ENTRY.
  - start and stop are ignored.
- ENTRY:
  - Valid key with digit_cnt<MAX_DIGITS: load pulse, digit_cnt+1.
  - Further keys once digit_cnt reaches MAX_DIGITS are ignored.
  - stop: timer_clear pulse, digit_cnt=0, go to IDLE.
  - start with door closed: tick_cnt=0, go to COOK.
  - start with door open: ignored.
- COOK:
  - magnetron_on=1.
  - tick_cnt counts 0..TICK_DIV-1 and wraps to 0. timer_enabled pulses for one cycle when tick_cnt==TICK_DIV-1. The first decrement occurs TICK_DIV cycles after entering COOK.
  - stop or door_open: go to PAUSED. magnetron_on=0 on the next cycle; tick_cnt holds. A tick coinciding with stop/door is suppressed.
  - timer_finished=1: go to DONE. This takes precedence over a same-cycle tick, but not over stop/door.
  - Keys are ignored.
- PAUSED:
  - tick_cnt holds.
  - start with door closed: resume COOK; tick_cnt continues from its held value.
  - stop: timer_clear pulse, digit_cnt=0, go to IDLE.
  - Keys are ignored.
- DONE:
  - beep=1 and magnetron_on=0; beep counter runs.
  - After BEEP_CYCLES cycles, or earlier on stop or door_open: beep=0, timer_clear pulse, digit_cnt=0, go to IDLE.
- Start in ENTRY with timer_finished already 1 (all-zero entry): COOK for exactly one cycle, then DONE; no timer_enabled pulse is issued.
- Outputs timer_load, timer_enabled and timer_clear are never high in the same cycle.
- Reset mid-COOK: magnetron_on drops the cycle after rst.

Test Plan:
- Digit entry: TICK_DIV=4; keys 1,3,0 -> three timer_load pulses with timer_in 1,3,0. Fifth key after four keys -> no load, state stays ENTRY.
- Cook to done: entry 0,0,0,2, start with door closed -> state=COOK and magnetron_on=1. timer_enabled pulses at cycles 4 and 8 after entry. Model timer_finished after the 2nd pulse -> state=DONE, beep=1. After BEEP_CYCLES=6 cycles -> beep=0, timer_clear pulse, state=IDLE.
- Door interlock: door_open mid-COOK with tick_cnt=2 -> PAUSED and magnetron_on=0. start while door still open -> stays PAUSED. Close door, start -> COOK; next timer_enabled arrives 2 cycles later.
- Cancel paths: stop in ENTRY -> timer_clear pulse, IDLE. Stop in PAUSED -> timer_clear pulse, IDLE. Stop in DONE -> beep=0 next cycle, IDLE.
- Simultaneous events: stop and timer_finished in same COOK cycle -> PAUSED, not DONE. Tick and door_open together -> no timer_enabled pulse.
- Reset: rst asserted in COOK and in DONE -> next cycle state=IDLE with all outputs 0. key_digit=11 in IDLE -> no load, stays IDLE.

Source files
------------

// File: rtl/microwave_controller.sv
// Sequencing FSM for the microwave MM:SS timer chain: keypad entry, cook/pause/cancel,
// one-per-second decrement strobe, magnetron drive and end-of-cook beep.
module microwave_controller #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned BEEP_CYCLES = 100_000_000,
    parameter int unsigned MAX_DIGITS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    input  logic       timer_finished,
    output logic       timer_load,
    output logic [3:0] timer_in,
    output logic       timer_enabled,
    output logic       timer_clear,
    output logic       magnetron_on,
    output logic       beep,
    output logic [2:0] state
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam int unsigned DIG_W  = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_COOK   = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    logic                r_timer_load;
    logic [3:0]          r_timer_in;
    logic                r_timer_enabled;
    logic                r_timer_clear;
    logic                r_magnetron_on;
    logic                r_beep;
    logic [DIG_W-1:0]    r_digit_cnt;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic [BEEP_W-1:0]   r_beep_cnt;

    logic w_key_ok;
    logic w_run_ok;
    logic w_tick_last;
    logic w_beep_last;

    assign w_key_ok    = key_valid && (key_digit <= 4'd9);
    assign w_run_ok    = start && !door_open;
    assign w_tick_last = (r_tick_cnt == TICK_W'(TICK_DIV - 1));
    assign w_beep_last = (r_beep_cnt == BEEP_W'(BEEP_CYCLES - 1));

    // State register with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_timer_load    <= 1'b0;
            r_timer_in      <= 4'd0;
            r_timer_enabled <= 1'b0;
            r_timer_clear   <= 1'b0;
            r_magnetron_on  <= 1'b0;
            r_beep          <= 1'b0;
            r_digit_cnt     <= '0;
            r_tick_cnt      <= '0;
            r_beep_cnt      <= '0;
        end else begin
            r_timer_load    <= 1'b0;
            r_timer_enabled <= 1'b0;
            r_timer_clear   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_key_ok) begin
                        r_timer_load <= 1'b1;
                        r_timer_in   <= key_digit;
                        r_digit_cnt  <= DIG_W'(1);
                        r_state      <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (stop) begin
                        r_timer_clear <= 1'b1;
                        r_digit_cnt   <= '0;
                        r_state       <= S_IDLE;
                    end else if (w_run_ok) begin
                        r_tick_cnt     <= '0;
                        r_magnetron_on <= 1'b1;
                        r_state        <= S_COOK;
                    end else if (w_key_ok && (r_digit_cnt < DIG_W'(MAX_DIGITS))) begin
                        r_timer_load <= 1'b1;
                        r_timer_in   <= key_digit;
                        r_digit_cnt  <= r_digit_cnt + DIG_W'(1);
                    end
                end
                S_COOK: begin
                    // Interlock beats finish, finish beats a same-cycle tick.
                    if (stop || door_open) begin
                        r_magnetron_on <= 1'b0;
                        r_state        <= S_PAUSED;
                    end else if (timer_finished) begin
                        r_magnetron_on <= 1'b0;
                        r_beep         <= 1'b1;
                        r_beep_cnt     <= '0;
                        r_state        <= S_DONE;
                    end else if (w_tick_last) begin
                        r_tick_cnt      <= '0;
                        r_timer_enabled <= 1'b1;
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                    end
                end
                S_PAUSED: begin
                    if (stop) begin
                        r_timer_clear <= 1'b1;
                        r_digit_cnt   <= '0;
                        r_state       <= S_IDLE;
                    end else if (w_run_ok) begin
                        r_magnetron_on <= 1'b1;
                        r_state        <= S_COOK;
                    end
                end
                S_DONE: begin
                    if (stop || door_open || w_beep_last) begin
                        r_beep        <= 1'b0;
                        r_timer_clear <= 1'b1;
                        r_digit_cnt   <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
                    end
                end
                default: begin
                    r_magnetron_on <= 1'b0;
                    r_beep         <= 1'b0;
                    r_state        <= S_IDLE;
                end
            endcase
        end
    end

    assign timer_load    = r_timer_load;
    assign timer_in      = r_timer_in;
    assign timer_enabled = r_timer_enabled;
    assign timer_clear   = r_timer_clear;
    assign magnetron_on  = r_magnetron_on;
    assign beep          = r_beep;
    assign state         = r_state;

endmodule

// File: tb/tb_microwave_controller.sv
// Bench for microwave_controller: directed scenarios plus random traffic, checked every
// cycle against a rule-level controller model and a BCD MM:SS timer environment.
module tb_microwave_controller;

    localparam int TICK_DIV    = 4;
    localparam int BEEP_CYCLES = 6;
    localparam int MAX_DIGITS  = 4;

    localparam int ST_IDLE   = 0;
    localparam int ST_ENTRY  = 1;
    localparam int ST_COOK   = 2;
    localparam int ST_PAUSED = 3;
    localparam int ST_DONE   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       start;
    logic       stop;
    logic       door_open;
    logic       timer_finished;
    logic       timer_load;
    logic [3:0] timer_in;
    logic       timer_enabled;
    logic       timer_clear;
    logic       magnetron_on;
    logic       beep;
    logic [2:0] state;

    microwave_controller #(
        .TICK_DIV   (TICK_DIV),
        .BEEP_CYCLES(BEEP_CYCLES),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_valid     (key_valid),
        .key_digit     (key_digit),
        .start         (start),
        .stop          (stop),
        .door_open     (door_open),
        .timer_finished(timer_finished),
        .timer_load    (timer_load),
        .timer_in      (timer_in),
        .timer_enabled (timer_enabled),
        .timer_clear   (timer_clear),
        .magnetron_on  (magnetron_on),
        .beep          (beep),
        .state         (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Timer environment: four BCD digits M1 M0 : S1 S0.
    int env_d[4] = '{0, 0, 0, 0};
    bit force_fin = 1'b0;

    // Controller model, expressed as the behavioural rules.
    int   m_state  = ST_IDLE;
    bit   m_load   = 0;
    int   m_tin    = 0;
    bit   m_en     = 0;
    bit   m_clr    = 0;
    int   ndig     = 0;
    int   elapsed  = 0;
    int   beep_age = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    endtask

    function automatic bit env_zero();
        return (env_d[0] == 0) && (env_d[1] == 0) && (env_d[2] == 0) && (env_d[3] == 0);
    endfunction

    task automatic env_update(input logic pl, input logic pe, input logic pc, input logic [3:0] pti);
        int mm;
        int ss;
        if (pc === 1'b1) begin
            env_d = '{0, 0, 0, 0};
        end else if (pl === 1'b1) begin
            env_d[0] = env_d[1];
            env_d[1] = env_d[2];
            env_d[2] = env_d[3];
            env_d[3] = int'(pti);
        end else if (pe === 1'b1) begin
            mm = env_d[0] * 10 + env_d[1];
            ss = env_d[2] * 10 + env_d[3];
            if (ss > 0) ss--;
            else if (mm > 0) begin
                mm--;
                ss = 59;
            end
            env_d = '{mm / 10, mm % 10, ss / 10, ss % 10};
        end
    endtask

    task automatic m_cancel();
        m_clr   = 1;
        ndig    = 0;
        m_state = ST_IDLE;
    endtask

    task automatic m_step(input logic r, input logic kv, input logic [3:0] kd,
                          input logic st, input logic sp, input logic dr, input logic fin);
        bit key_ok;
        bit run_ok;
        m_load = 0;
        m_en   = 0;
        m_clr  = 0;
        if (r) begin
            m_state = ST_IDLE; m_tin = 0; ndig = 0; elapsed = 0; beep_age = 0;
            return;
        end
        key_ok = kv && (kd < 10);
        run_ok = st && !dr;
        case (m_state)
            ST_IDLE: if (key_ok) begin
                m_load = 1; m_tin = int'(kd); ndig = 1; m_state = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (sp) m_cancel();
                else if (run_ok) begin
                    elapsed = 0; m_state = ST_COOK;
                end else if (key_ok && ndig < MAX_DIGITS) begin
                    m_load = 1; m_tin = int'(kd); ndig++;
                end
            end
            ST_COOK: begin
                if (sp || dr) m_state = ST_PAUSED;
                else if (fin) begin
                    m_state = ST_DONE; beep_age = 0;
                end else begin
                    // A decrement every TICK_DIV cooking cycles, counted across pauses.
                    elapsed++;
                    m_en = (elapsed % TICK_DIV) == 0;
                end
            end
            ST_PAUSED: begin
                if (sp) m_cancel();
                else if (run_ok) m_state = ST_COOK;
            end
            ST_DONE: begin
                beep_age++;
                if (sp || dr || beep_age >= BEEP_CYCLES) m_cancel();
            end
            default: m_state = ST_IDLE;
        endcase
    endtask

    // One clock cycle: drive inputs, advance model and timer at the edge, compare after it.
    task automatic step(input logic r, input logic kv, input logic [3:0] kd,
                        input logic st, input logic sp, input logic dr);
        logic fin;
        logic pl, pe, pc;
        logic [3:0] pti;
        fin = env_zero() || force_fin;
        rst = r; key_valid = kv; key_digit = kd; start = st; stop = sp; door_open = dr;
        timer_finished = fin;
        pl = timer_load; pe = timer_enabled; pc = timer_clear; pti = timer_in;
        @(posedge clk);
        m_step(r, kv, kd, st, sp, dr, fin);
        env_update(pl, pe, pc, pti);
        #1;
        chk("state", 32'(state), 32'(m_state));
        chk("timer_load", 32'(timer_load), 32'(m_load));
        chk("timer_in", 32'(timer_in), 32'(m_tin));
        chk("timer_enabled", 32'(timer_enabled), 32'(m_en));
        chk("timer_clear", 32'(timer_clear), 32'(m_clr));
        chk("magnetron_on", 32'(magnetron_on), 32'(m_state == ST_COOK));
        chk("beep", 32'(beep), 32'(m_state == ST_DONE));
        chk("strobe_exclusive",
            32'(int'(timer_load) + int'(timer_enabled) + int'(timer_clear) <= 1), 32'd1);
    endtask

    task automatic idle();
        step(0, 0, 4'd0, 0, 0, 0);
    endtask

    task automatic key(input int d);
        step(0, 1, 4'(d), 0, 0, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_outs"},
            32'({timer_load, timer_in, timer_enabled, timer_clear, magnetron_on, beep}), 32'd0);
    endtask

    initial begin
        bit seen;
        // Reset state
        step(1, 0, 4'd0, 0, 0, 0);
        chk_all_zero("reset");
        idle();

        // Digit entry and the digit cap
        key(1); chk("load1", 32'(timer_load), 1); chk("tin1", 32'(timer_in), 1);
        key(3); chk("load3", 32'(timer_load), 1); chk("tin3", 32'(timer_in), 3);
        key(0); chk("load0", 32'(timer_load), 1); chk("tin0", 32'(timer_in), 0);
        key(5); chk("load_4th", 32'(timer_load), 1);
        key(7); chk("load_5th", 32'(timer_load), 0); chk("state_5th", 32'(state), ST_ENTRY);
        step(0, 0, 4'd0, 0, 1, 0);
        chk("entry_stop_clr", 32'(timer_clear), 1); chk("entry_stop_state", 32'(state), ST_IDLE);

        // Cook 00:02 to completion
        key(0); key(0); key(0); key(2);
        step(0, 0, 4'd0, 1, 0, 0);
        chk("cook_state", 32'(state), ST_COOK); chk("cook_mag", 32'(magnetron_on), 1);
        for (int i = 1; i <= 8; i++) begin
            idle();
            chk($sformatf("tick_c%0d", i), 32'(timer_enabled), 32'(i == 4 || i == 8));
        end
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            idle();
            seen = (state == 3'(ST_DONE));
        end
        chk("reach_done", 32'(seen), 1); chk("done_beep", 32'(beep), 1);
        for (int i = 1; i <= BEEP_CYCLES; i++) begin
            idle();
            chk($sformatf("beep_c%0d", i), 32'(beep), 32'(i < BEEP_CYCLES));
            chk($sformatf("done_clr_c%0d", i), 32'(timer_clear), 32'(i == BEEP_CYCLES));
        end
        chk("done_to_idle", 32'(state), ST_IDLE);

        // Door interlock, resume, stop in PAUSED
        key(9); key(9);
        step(0, 0, 4'd0, 1, 0, 0); idle(); idle();
        step(0, 0, 4'd0, 0, 0, 1);
        chk("door_paused", 32'(state), ST_PAUSED); chk("door_mag", 32'(magnetron_on), 0);
        step(0, 0, 4'd0, 1, 0, 1);
        chk("start_door_open", 32'(state), ST_PAUSED);
        step(0, 0, 4'd0, 1, 0, 0);
        chk("resume", 32'(state), ST_COOK); chk("resume_mag", 32'(magnetron_on), 1);
        idle(); chk("resume_t1", 32'(timer_enabled), 0);
        idle(); chk("resume_t2", 32'(timer_enabled), 1);
        step(0, 0, 4'd0, 0, 0, 1);
        step(0, 0, 4'd0, 0, 1, 0);
        chk("paused_stop_clr", 32'(timer_clear), 1); chk("paused_stop_state", 32'(state), ST_IDLE);

        // All-zero entry: one COOK cycle then DONE; stop in DONE
        key(0);
        step(0, 0, 4'd0, 1, 0, 0);
        chk("zero_cook", 32'(state), ST_COOK);
        idle();
        chk("zero_done", 32'(state), ST_DONE); chk("zero_no_tick", 32'(timer_enabled), 0);
        step(0, 0, 4'd0, 0, 1, 0);
        chk("done_stop_beep", 32'(beep), 0); chk("done_stop_state", 32'(state), ST_IDLE);
        chk("done_stop_clr", 32'(timer_clear), 1);

        // Stop with finish in the same cycle; tick with door open
        key(5);
        step(0, 0, 4'd0, 1, 0, 0);
        force_fin = 1;
        step(0, 0, 4'd0, 0, 1, 0);
        force_fin = 0;
        chk("stop_beats_finish", 32'(state), ST_PAUSED);
        step(0, 0, 4'd0, 0, 1, 0);
        key(5);
        step(0, 0, 4'd0, 1, 0, 0); idle(); idle(); idle();
        step(0, 0, 4'd0, 0, 0, 1);
        chk("door_tick_suppressed", 32'(timer_enabled), 0);
        chk("door_tick_state", 32'(state), ST_PAUSED);
        step(0, 0, 4'd0, 0, 1, 0);

        // Reset in COOK and in DONE; invalid digit in IDLE
        key(7);
        step(0, 0, 4'd0, 1, 0, 0); idle();
        step(1, 0, 4'd0, 0, 0, 0);
        chk_all_zero("rst_cook");
        key(1);
        step(0, 0, 4'd0, 1, 0, 0);
        force_fin = 1;
        idle();
        force_fin = 0;
        chk("pre_rst_done", 32'(state), ST_DONE);
        step(1, 0, 4'd0, 0, 0, 0);
        chk_all_zero("rst_done");
        key(11);
        chk("bad_digit_load", 32'(timer_load), 0); chk("bad_digit_state", 32'(state), ST_IDLE);

        // Random traffic against the model
        for (int i = 0; i < 700; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 3),
                 4'($urandom_range(0, 12)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 11) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
